// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_fifo
// Brief    : FWFT result FIFO behind the 8-bit ALU. Results arriving while
//            full are dropped and counted. Optional entry parity when the
//            macro ALU_FIFO_PARITY_EN is defined.
// Revision : 1.0
// ============================================================================
module alu_result_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
`ifdef ALU_FIFO_PARITY_EN
  input  logic              i_corrupt,
  output logic              o_parity_err,
`endif
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [AW:0]       o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic [7:0]        o_drop_cnt
);

  localparam logic [AW:0] c_FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  c_DROP_MAX = 8'hFF;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [7:0]        r_drop_cnt;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Flags come only from the registered count, so no input reaches them.
  assign w_full  = (r_count == c_FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && i_ready;
  assign w_push  = i_valid && (!w_full || w_pop);
  assign w_drop  = i_valid && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_drop && (r_drop_cnt != c_DROP_MAX)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

`ifdef ALU_FIFO_PARITY_EN
  logic r_par [DEPTH];
  logic r_parity_err;

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) begin
      r_par[r_wr_ptr] <= (^i_data) ^ i_corrupt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_pop && (r_par[r_rd_ptr] != (^r_mem[r_rd_ptr]));
    end
  end

  assign o_parity_err = r_parity_err;
`endif

  assign o_valid    = !w_empty;
  assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the 8-bit ALU. Captures every result the ALU flags valid into a first-word-fall-through FIFO.
- Releases results to the consumer over a valid/ready handshake.
- The ALU has no backpressure, so results arriving while the FIFO is full are dropped and counted.

Parameters:
- DATA_W, 8: result width; matches the ALU result bus.
- DEPTH, 8: number of entries; must be a power of two and at least 2. Address width AW = log2(DEPTH).

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_valid  input  1  ALU result valid; connects to the ALU o_valid.
- i_data  input  DATA_W  ALU result; connects to the ALU o_result.
- i_ready  input  1  consumer ready.
- o_valid  output  1  head entry available; equal to not-empty.
- o_data  output  DATA_W  head entry (FWFT); 0 when empty.
- o_count  output  AW+1  number of entries held, 0..DEPTH.
- o_full  output  1  o_count == DEPTH.
- o_empty  output  1  o_count == 0.
- o_drop_cnt  output  8  saturating count of dropped results.

Behaviour:
- Reset (i_rst high at a rising edge):
  - write and read pointers, count and drop counter go to 0.
  - o_valid=0, o_empty=1, o_full=0, o_data=0, o_drop_cnt=0.
  - Storage array is not reset.
- Reset mid-operation: all queued entries are discarded. i_valid and i_ready are ignored during any cycle with i_rst high.
- push = i_valid && (!o_full || pop).
- pop = o_valid && i_ready. A pop when empty is impossible, since o_valid is low.
- On push: mem[wr_ptr] <= i_data, and wr_ptr advances modulo DEPTH (natural AW-bit wrap).
- On pop: rd_ptr advances modulo DEPTH.
- o_count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Write-to-read latency: data pushed at edge N is visible on o_data with o_valid=1 in the cycle after edge N. No same-cycle bypass: empty with i_valid=1 gives o_valid=0 that cycle.
- o_data: combinational read of mem[rd_ptr], muxed to 0 when empty. Stable while o_valid && !i_ready.
- Full with simultaneous pop and i_valid: the write is accepted, count stays at DEPTH, and no drop is recorded.
- Drop condition: i_valid && o_full && !pop. i_data is discarded and o_drop_cnt increments, saturating at 255 (no wrap). Queue contents and pointers are unchanged.
- Throughput: 1 push and 1 pop per cycle sustained.
- o_full, o_empty and o_valid are derived from registered o_count, so there are no combinational paths from inputs to flags.
- o_data and the flags never change in the absence of push, pop or reset.

Optional Feature:
- Macro: ALU_FIFO_PARITY_EN.
- Defined:
  - Each entry stores an extra bit, the even parity (XOR-reduce) of i_data, computed at push.
  - Extra output o_parity_err (1 bit, registered, reset 0) is set for one cycle after any pop whose stored parity does not match the XOR-reduce of the popped data.
  - Bench test hook: input i_corrupt (1 bit) inverts the stored parity bit of the entry pushed that cycle.
- Not defined: no parity storage, and neither o_parity_err nor i_corrupt exist in the port list.

Test Plan:
1. Reset: hold i_rst=1 for 2 cycles with i_valid=1 and i_data=0xAA -> o_empty=1, o_count=0, o_valid=0, o_data=0x00, o_drop_cnt=0.
2. Ordering: with i_ready=0, push 0x12, 0x34, 0x56 -> o_count=3 and o_data=0x12. Then set i_ready=1 -> o_data shows 0x12, 0x34, 0x56 on consecutive cycles, then o_empty=1.
3. Overflow: with i_ready=0, push 0x01..0x0A (10 values) into DEPTH=8 -> o_full=1, o_drop_cnt=2. Draining yields 0x01..0x08 only. A further 300 pushes while full -> o_drop_cnt holds at 255.
4. Full with simultaneous read/write: start full with 0x01..0x08, pulse i_ready=1 and i_valid=1 with 0xEE -> o_count stays 8, o_drop_cnt unchanged, and the drain order is 0x02..0x08, 0xEE.
5. Wrap/streaming: 20 consecutive pushes of 0x00..0x13 with i_ready=1 -> each value appears one cycle after its push, o_count<=1, no drops, and the pointers wrap twice.
6. Reset mid-operation: with 5 entries queued and o_drop_cnt=3, assert i_rst for 1 cycle -> the next cycle shows o_empty=1, o_drop_cnt=0, and a subsequent push of 0x77 appears as the head.
